// File: rtl/usr_controller.sv
// usr_controller: command sequencer for an 8-bit universal shift register.
// Accepts LOAD/SHR/SHL/ROR/ROL over valid/ready and drives the register's
// mode, parallel and serial inputs for exactly the commanded number of steps.
// Between commands the register reloads its own output, so its contents hold.
module usr_controller #(
  parameter int WIDTH = 8,
  parameter int CW    = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [2:0]       cmd_op,
  input  logic [CW-1:0]    cmd_count,
  input  logic [WIDTH-1:0] cmd_data,
  input  logic             abort,
  output logic             busy,
  output logic             done,
  output logic             err,
  input  logic [WIDTH-1:0] usr_q,
  output logic [2:0]       usr_mode,
  output logic [WIDTH-1:0] usr_parallel_in,
  output logic             usr_serial_in
);

  // The step counter must be able to hold WIDTH itself (count 0 means WIDTH).
  localparam int LW = CW + 1;

  localparam logic [2:0] OP_LOAD = 3'd0;
  localparam logic [2:0] OP_SHR  = 3'd1;
  localparam logic [2:0] OP_SHL  = 3'd2;
  localparam logic [2:0] OP_ROR  = 3'd3;
  localparam logic [2:0] OP_ROL  = 3'd4;

  localparam logic [2:0] MODE_LOAD = 3'b001;
  localparam logic [2:0] MODE_SR   = 3'b100;
  localparam logic [2:0] MODE_SL   = 3'b101;
  localparam logic [2:0] MODE_ROR  = 3'b110;
  localparam logic [2:0] MODE_ROL  = 3'b111;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state_reg;
  logic [2:0]       op_reg;
  logic [WIDTH-1:0] sbuf_reg;
  logic [LW-1:0]    left_reg;
  logic             done_reg;
  logic             err_reg;

  logic             op_legal;
  logic [LW-1:0]    steps_next;
  logic [2:0]       run_mode;

  assign op_legal = (cmd_op <= OP_ROL);

  // Step count for a newly accepted command: LOAD is one step, 0 means WIDTH.
  always_comb begin
    steps_next = {1'b0, cmd_count};
    if (cmd_op == OP_LOAD) begin
      steps_next = LW'(1);
    end else if (cmd_count == '0) begin
      steps_next = LW'(WIDTH);
    end
  end

  // Sequencer state, latched command and registered done/err pulses.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= IDLE;
      op_reg    <= OP_LOAD;
      sbuf_reg  <= '0;
      left_reg  <= '0;
      done_reg  <= 1'b0;
      err_reg   <= 1'b0;
    end else begin
      done_reg <= 1'b0;
      err_reg  <= 1'b0;
      case (state_reg)
        IDLE: begin
          if (cmd_valid) begin
            op_reg   <= cmd_op;
            sbuf_reg <= cmd_data;
            left_reg <= steps_next;
            if (op_legal) begin
              state_reg <= RUN;
            end else begin
              // Illegal ops are consumed with an err pulse; ready stays high.
              err_reg <= 1'b1;
            end
          end
        end
        RUN: begin
          // The step driven this cycle always executes, even when aborted.
          sbuf_reg <= sbuf_reg >> 1;
          left_reg <= left_reg - LW'(1);
          if (abort) begin
            state_reg <= IDLE;
          end else if (left_reg == LW'(1)) begin
            state_reg <= DONE;
            done_reg  <= 1'b1;
          end
        end
        DONE: begin
          state_reg <= IDLE;
        end
        default: begin
          state_reg <= IDLE;
        end
      endcase
    end
  end

  // Register mode for the latched op while running.
  always_comb begin
    case (op_reg)
      OP_SHR:  run_mode = MODE_SR;
      OP_SHL:  run_mode = MODE_SL;
      OP_ROR:  run_mode = MODE_ROR;
      OP_ROL:  run_mode = MODE_ROL;
      default: run_mode = MODE_LOAD;
    endcase
  end

  // Register drive: the op's step while running, a self-reload otherwise.
  always_comb begin
    usr_mode        = MODE_LOAD;
    usr_parallel_in = usr_q;
    usr_serial_in   = 1'b0;
    if (state_reg == RUN) begin
      usr_mode = run_mode;
      if (op_reg == OP_LOAD) begin
        usr_parallel_in = sbuf_reg;
      end
      if ((op_reg == OP_SHR) || (op_reg == OP_SHL)) begin
        usr_serial_in = sbuf_reg[0];
      end
    end
  end

  assign cmd_ready = (state_reg == IDLE);
  assign busy      = (state_reg != IDLE);
  assign done      = done_reg;
  assign err       = err_reg;

endmodule

// File: tb/tb_usr_controller.sv
// Directed testbench for usr_controller with a behavioural shift register
// closing the usr_q feedback loop.
`timescale 1ns/1ps
module tb_usr_controller;

  logic       clk;
  logic       rst;
  logic       cmd_valid;
  logic       cmd_ready;
  logic [2:0] cmd_op;
  logic [2:0] cmd_count;
  logic [7:0] cmd_data;
  logic       abort;
  logic       busy;
  logic       done;
  logic       err;
  logic [7:0] usr_q;
  logic [2:0] usr_mode;
  logic [7:0] usr_parallel_in;
  logic       usr_serial_in;

  logic       preload_en;
  logic [7:0] preload_val;
  logic [7:0] reg_q;

  int total;
  int bad;

  usr_controller #(.WIDTH(8)) dut (
    .clk(clk),
    .rst(rst),
    .cmd_valid(cmd_valid),
    .cmd_ready(cmd_ready),
    .cmd_op(cmd_op),
    .cmd_count(cmd_count),
    .cmd_data(cmd_data),
    .abort(abort),
    .busy(busy),
    .done(done),
    .err(err),
    .usr_q(usr_q),
    .usr_mode(usr_mode),
    .usr_parallel_in(usr_parallel_in),
    .usr_serial_in(usr_serial_in)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Universal shift register model driven by the controller.
  always @(posedge clk) begin
    if (preload_en) reg_q <= preload_val;
    else begin
      case (usr_mode)
        3'b001:  reg_q <= usr_parallel_in;
        3'b100:  reg_q <= {usr_serial_in, reg_q[7:1]};
        3'b101:  reg_q <= {reg_q[6:0], usr_serial_in};
        3'b110:  reg_q <= {reg_q[0], reg_q[7:1]};
        3'b111:  reg_q <= {reg_q[6:0], reg_q[7]};
        default: reg_q <= reg_q;
      endcase
    end
  end
  assign usr_q = reg_q;

  // Force the register contents while the controller is idle.
  task automatic set_q(input logic [7:0] v);
    @(negedge clk);
    preload_en  = 1'b1;
    preload_val = v;
    @(posedge clk);
    #1 preload_en = 1'b0;
  endtask

  // Present one command; returns 1ns after the accepting edge.
  task automatic send(input logic [2:0] op, input logic [2:0] cnt, input logic [7:0] data);
    @(negedge clk);
    cmd_valid = 1'b1;
    cmd_op    = op;
    cmd_count = cnt;
    cmd_data  = data;
    @(posedge clk);
    #1;
    cmd_valid = 1'b0;
    cmd_op    = 3'd0;
    cmd_count = 3'd0;
    cmd_data  = 8'h00;
  endtask

  task automatic test_reset();
    rst         = 1'b1;
    preload_en  = 1'b1;
    preload_val = 8'h3C;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst        = 1'b0;
    preload_en = 1'b0;
    total++;
    if (usr_mode !== 3'b001) begin
      bad++;
      $display("FAIL reset_mode: got %b want 001", usr_mode);
    end
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      total++;
      if (usr_q !== 8'h3C) begin
        bad++;
        $display("FAIL idle_hold_q cyc %0d: got %h want 3c", i, usr_q);
      end
      total++;
      if ({busy, cmd_ready, done, err} !== 4'b0100) begin
        bad++;
        $display("FAIL idle_flags cyc %0d: busy/ready/done/err got %b want 0100", i, {busy, cmd_ready, done, err});
      end
    end
    $display("reset+idle: q=%h busy=%b ready=%b", usr_q, busy, cmd_ready);
  endtask

  task automatic test_load();
    set_q(8'h00);
    send(3'd0, 3'd5, 8'hA5);
    @(negedge clk);  // cycle k+1
    total++;
    if ({busy, cmd_ready, done} !== 3'b100 || usr_mode !== 3'b001 || usr_parallel_in !== 8'hA5) begin
      bad++;
      $display("FAIL load_run: busy/ready/done=%b mode=%b pin=%h want 100 001 a5", {busy, cmd_ready, done}, usr_mode, usr_parallel_in);
    end
    @(negedge clk);  // cycle k+2
    total++;
    if (usr_q !== 8'hA5 || done !== 1'b1 || cmd_ready !== 1'b0) begin
      bad++;
      $display("FAIL load_done: q=%h done=%b ready=%b want a5 1 0", usr_q, done, cmd_ready);
    end
    @(negedge clk);  // cycle k+3
    total++;
    if (usr_q !== 8'hA5 || done !== 1'b0 || cmd_ready !== 1'b1) begin
      bad++;
      $display("FAIL load_after: q=%h done=%b ready=%b want a5 0 1", usr_q, done, cmd_ready);
    end
    $display("LOAD a5: q=%h", usr_q);
  endtask

  task automatic test_shift();
    logic [7:0] exp_r [3];
    logic [7:0] exp_l [2];
    exp_r[0] = 8'hF8; exp_r[1] = 8'h7C; exp_r[2] = 8'hBE;
    exp_l[0] = 8'h03; exp_l[1] = 8'h07;
    set_q(8'hF0);
    send(3'd1, 3'd3, 8'h05);
    @(negedge clk);
    total++;
    if (usr_mode !== 3'b100 || usr_serial_in !== 1'b1) begin
      bad++;
      $display("FAIL shr_drive: mode=%b sin=%b want 100 1", usr_mode, usr_serial_in);
    end
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      total++;
      if (usr_q !== exp_r[i] || done !== (i == 2)) begin
        bad++;
        $display("FAIL shr_step %0d: q=%h done=%b want %h %b", i, usr_q, done, exp_r[i], (i == 2));
      end
    end
    @(negedge clk);
    total++;
    if (cmd_ready !== 1'b1 || done !== 1'b0 || usr_q !== 8'hBE) begin
      bad++;
      $display("FAIL shr_end: ready=%b done=%b q=%h want 1 0 be", cmd_ready, done, usr_q);
    end
    $display("SHR 3 on f0: q=%h", usr_q);

    set_q(8'h01);
    send(3'd2, 3'd2, 8'h03);
    @(negedge clk);
    total++;
    if (usr_mode !== 3'b101) begin
      bad++;
      $display("FAIL shl_mode: got %b want 101", usr_mode);
    end
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      total++;
      if (usr_q !== exp_l[i] || done !== (i == 1)) begin
        bad++;
        $display("FAIL shl_step %0d: q=%h done=%b want %h %b", i, usr_q, done, exp_l[i], (i == 1));
      end
    end
    $display("SHL 2 on 01: q=%h", usr_q);
  endtask

  task automatic test_rotate();
    logic [7:0] exp_rol [8];
    exp_rol[0] = 8'h03; exp_rol[1] = 8'h06; exp_rol[2] = 8'h0C; exp_rol[3] = 8'h18;
    exp_rol[4] = 8'h30; exp_rol[5] = 8'h60; exp_rol[6] = 8'hC0; exp_rol[7] = 8'h81;
    set_q(8'h81);
    send(3'd4, 3'd0, 8'hFF);
    @(negedge clk);
    total++;
    if (usr_mode !== 3'b111 || busy !== 1'b1) begin
      bad++;
      $display("FAIL rol_drive: mode=%b busy=%b want 111 1", usr_mode, busy);
    end
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      total++;
      if (usr_q !== exp_rol[i] || done !== (i == 7)) begin
        bad++;
        $display("FAIL rol_step %0d: q=%h done=%b want %h %b", i, usr_q, done, exp_rol[i], (i == 7));
      end
    end
    $display("ROL 8 on 81: q=%h", usr_q);

    set_q(8'h01);
    send(3'd3, 3'd1, 8'h00);
    @(negedge clk);
    @(negedge clk);
    total++;
    if (usr_q !== 8'h80 || done !== 1'b1) begin
      bad++;
      $display("FAIL ror1: q=%h done=%b want 80 1", usr_q, done);
    end
    $display("ROR 1 on 01: q=%h", usr_q);
  endtask

  task automatic test_abort();
    set_q(8'h0F);
    send(3'd3, 3'd4, 8'h00);
    @(negedge clk);  // first RUN cycle
    @(negedge clk);  // second RUN cycle
    total++;
    if (usr_q !== 8'h87 || busy !== 1'b1) begin
      bad++;
      $display("FAIL abort_step1: q=%h busy=%b want 87 1", usr_q, busy);
    end
    abort = 1'b1;
    @(posedge clk);
    #1 abort = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      total++;
      if (usr_q !== 8'hC3 || done !== 1'b0 || busy !== 1'b0 || cmd_ready !== 1'b1) begin
        bad++;
        $display("FAIL abort_hold %0d: q=%h done=%b busy=%b ready=%b want c3 0 0 1", i, usr_q, done, busy, cmd_ready);
      end
    end
    $display("ROR abort mid: q=%h", usr_q);

    set_q(8'h0F);
    send(3'd3, 3'd2, 8'h00);
    @(negedge clk);
    @(negedge clk);  // final RUN cycle
    abort = 1'b1;
    @(posedge clk);
    #1 abort = 1'b0;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      total++;
      if (usr_q !== 8'hC3 || done !== 1'b0 || cmd_ready !== 1'b1) begin
        bad++;
        $display("FAIL abort_last %0d: q=%h done=%b ready=%b want c3 0 1", i, usr_q, done, cmd_ready);
      end
    end
    $display("ROR abort last: q=%h", usr_q);
  endtask

  task automatic test_illegal();
    set_q(8'h5A);
    send(3'd5, 3'd3, 8'hFF);
    @(negedge clk);
    total++;
    if ({err, done, busy, cmd_ready} !== 4'b1001 || usr_q !== 8'h5A) begin
      bad++;
      $display("FAIL illegal_err: err/done/busy/ready=%b q=%h want 1001 5a", {err, done, busy, cmd_ready}, usr_q);
    end
    @(negedge clk);
    total++;
    if (err !== 1'b0 || usr_q !== 8'h5A) begin
      bad++;
      $display("FAIL illegal_pulse: err=%b q=%h want 0 5a", err, usr_q);
    end
    // Two illegal commands on consecutive edges.
    cmd_valid = 1'b1;
    cmd_op    = 3'd6;
    @(posedge clk);
    #1 cmd_op = 3'd7;
    @(negedge clk);
    total++;
    if (err !== 1'b1 || cmd_ready !== 1'b1) begin
      bad++;
      $display("FAIL illegal_b2b_1: err=%b ready=%b want 1 1", err, cmd_ready);
    end
    @(posedge clk);
    #1 cmd_valid = 1'b0;
    cmd_op = 3'd0;
    @(negedge clk);
    total++;
    if (err !== 1'b1 || done !== 1'b0) begin
      bad++;
      $display("FAIL illegal_b2b_2: err=%b done=%b want 1 0", err, done);
    end
    @(negedge clk);
    total++;
    if (err !== 1'b0 || usr_q !== 8'h5A) begin
      bad++;
      $display("FAIL illegal_b2b_end: err=%b q=%h want 0 5a", err, usr_q);
    end
    $display("illegal ops: q=%h", usr_q);
  endtask

  task automatic test_reset_mid_run();
    set_q(8'h01);
    send(3'd2, 3'd6, 8'h00);
    @(negedge clk);
    @(negedge clk);
    total++;
    if (usr_q !== 8'h02 || busy !== 1'b1) begin
      bad++;
      $display("FAIL rstrun_step: q=%h busy=%b want 02 1", usr_q, busy);
    end
    rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    total++;
    if ({busy, cmd_ready, done, err} !== 4'b0100 || usr_mode !== 3'b001) begin
      bad++;
      $display("FAIL rstrun_idle: busy/ready/done/err=%b mode=%b want 0100 001", {busy, cmd_ready, done, err}, usr_mode);
    end
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      total++;
      if (done !== 1'b0 || busy !== 1'b0 || usr_q !== 8'h04) begin
        bad++;
        $display("FAIL rstrun_hold %0d: done=%b busy=%b q=%h want 0 0 04", i, done, busy, usr_q);
      end
    end
    $display("reset mid-run: q=%h", usr_q);
  endtask

  initial begin
    total       = 0;
    bad         = 0;
    rst         = 1'b1;
    cmd_valid   = 1'b0;
    cmd_op      = 3'd0;
    cmd_count   = 3'd0;
    cmd_data    = 8'h00;
    abort       = 1'b0;
    preload_en  = 1'b0;
    preload_val = 8'h00;
    test_reset();
    test_load();
    test_shift();
    test_rotate();
    test_abort();
    test_illegal();
    test_reset_mid_run();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
